framebuffer_arbiter: RTL and testbench

Shares one single-port framebuffer RAM between two requesters. The video scanout read stream gets bounded-latency reads. The CPU/graphics write stream writes pixels. The block sits between the video controller's framebuffer interface and the RAM, and issues at most one RAM operation per cycle. It holds a 3-entry read-return FIFO with credit-based issue, so video reads run at full rate under backpressure. A starvation counter guarantees that CPU writes make forward progress.

---
 rtl/framebuffer_arbiter_if.sv | 52 +++++
 rtl/framebuffer_arbiter.sv | 115 +++++++++++
 tb/tb_framebuffer_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_arbiter_if.sv
// ============================================================================
// Module   : framebuffer_arbiter_if
// Brief    : Video read, CPU write and RAM port bundle for the framebuffer arbiter
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface framebuffer_arbiter_if #(
    parameter int RAM_WIDTH     = 24,
    parameter int RAM_ADDR_BITS = 20
) ();
    logic [RAM_ADDR_BITS-1:0] vid_addr;
    logic                     vid_addr_valid;
    logic                     vid_addr_rdy;
    logic [RAM_WIDTH-1:0]     vid_data;
    logic                     vid_data_valid;
    logic                     vid_data_rdy;

    logic [RAM_ADDR_BITS-1:0] cpu_addr;
    logic [RAM_WIDTH-1:0]     cpu_wdata;
    logic [2:0]               cpu_wmask;
    logic                     cpu_valid;
    logic                     cpu_rdy;

    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic                     ram_en;
    logic [2:0]               ram_we;
    logic [RAM_WIDTH-1:0]     ram_wdata;
    logic [RAM_WIDTH-1:0]     ram_rdata;

    // Arbiter side
    modport slave (
        input  vid_addr, vid_addr_valid, vid_data_rdy,
        input  cpu_addr, cpu_wdata, cpu_wmask, cpu_valid,
        input  ram_rdata,
        output vid_addr_rdy, vid_data, vid_data_valid,
        output cpu_rdy,
        output ram_addr, ram_en, ram_we, ram_wdata
    );

    // Requester / RAM side
    modport master (
        output vid_addr, vid_addr_valid, vid_data_rdy,
        output cpu_addr, cpu_wdata, cpu_wmask, cpu_valid,
        output ram_rdata,
        input  vid_addr_rdy, vid_data, vid_data_valid,
        input  cpu_rdy,
        input  ram_addr, ram_en, ram_we, ram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
// ============================================================================
// Module   : framebuffer_arbiter
// Brief    : Single-port framebuffer RAM arbiter, credit-based video reads with
//            a 3-entry return FIFO and a starvation guard for CPU writes
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module framebuffer_arbiter #(
    parameter int RAM_WIDTH        = 24,
    parameter int RAM_ADDR_BITS    = 20,
    parameter int CPU_STARVE_LIMIT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    framebuffer_arbiter_if.slave   bus
);

    localparam int                  c_STARVE_W   = $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(CPU_STARVE_LIMIT);
    localparam logic [1:0]          c_PTR_LAST   = 2'd2;

    logic [RAM_WIDTH-1:0]  fifo_mem_q [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            fifo_count_q, fifo_count_d;
    logic                  inflight_q, inflight_d;
    logic [c_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic w_credit;
    logic w_force;
    logic w_vid_fire;
    logic w_cpu_fire;
    logic w_push;
    logic w_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == c_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Credit counts the read still in the RAM, so a pop this cycle never frees a slot early.
    assign w_credit = ({1'b0, fifo_count_q} + {2'b00, inflight_q}) <= 3'd2;
    assign w_force  = (starve_cnt_q == c_STARVE_MAX) && bus.cpu_valid;

    assign bus.vid_addr_rdy = !rst && w_credit && !w_force;
    assign bus.cpu_rdy      = !rst && (w_force || !(bus.vid_addr_valid && w_credit));

    assign w_vid_fire = bus.vid_addr_valid && bus.vid_addr_rdy;
    assign w_cpu_fire = bus.cpu_valid && bus.cpu_rdy;

    assign w_push = inflight_q;
    assign w_pop  = bus.vid_data_valid && bus.vid_data_rdy;

    assign bus.vid_data_valid = (fifo_count_q != 2'd0);
    assign bus.vid_data       = fifo_mem_q[rd_ptr_q];

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 3'b000;
        bus.ram_addr  = bus.vid_addr;
        bus.ram_wdata = bus.cpu_wdata;
        if (w_vid_fire) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.vid_addr;
        end else if (w_cpu_fire) begin
            // An all-zero mask is consumed silently so it cannot look like a read.
            bus.ram_en   = (bus.cpu_wmask != 3'b000);
            bus.ram_we   = bus.cpu_wmask;
            bus.ram_addr = bus.cpu_addr;
        end
    end

    always_comb begin
        inflight_d   = w_vid_fire;
        wr_ptr_d     = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        case ({w_push, w_pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
        starve_cnt_d = starve_cnt_q;
        if (w_cpu_fire || !bus.cpu_valid) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != c_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 2'd0;
            inflight_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.ram_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
// ============================================================================
// Module   : tb_framebuffer_arbiter
// Brief    : Self-checking bench for framebuffer_arbiter with RAM model and
//            shadow-memory scoreboard
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_framebuffer_arbiter;

    localparam int W     = 24;
    localparam int A     = 20;
    localparam int LIMIT = 16;
    localparam int MEMN  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    framebuffer_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

    framebuffer_arbiter #(
        .RAM_WIDTH(W), .RAM_ADDR_BITS(A), .CPU_STARVE_LIMIT(LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ram_mem [MEMN];
    logic [W-1:0] shadow  [MEMN];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] ram_rdata_q = '0;
    int           cpu_wait = 0;

    assign bus.ram_rdata = ram_rdata_q;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                           input logic [2:0] m);
        logic [W-1:0] r;
        r = old_v;
        for (int b = 0; b < 3; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Single-port RAM: unwritten words hold their own address.
    initial begin
        for (int i = 0; i < MEMN; i++) ram_mem[i] = W'(i);
        forever begin
            @(posedge clk);
            if (bus.ram_en) begin
                if (bus.ram_we == 3'b000) ram_rdata_q <= ram_mem[bus.ram_addr[9:0]];
                else ram_mem[bus.ram_addr[9:0]] <= merge(ram_mem[bus.ram_addr[9:0]], bus.ram_wdata, bus.ram_we);
            end
        end
    end

    // Scoreboard: grant-order shadow memory, expected read-return queue, starvation bound.
    initial begin
        logic [W-1:0] exp_v;
        logic         vf, cf;
        for (int i = 0; i < MEMN; i++) shadow[i] = W'(i);
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
                cpu_wait = 0;
            end else begin
                vf = bus.vid_addr_valid && bus.vid_addr_rdy;
                cf = bus.cpu_valid && bus.cpu_rdy;
                if (bus.vid_data_valid && bus.vid_data_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_pop: vid_data=%h popped, no read outstanding", bus.vid_data);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (bus.vid_data !== exp_v) begin
                            failures++;
                            $display("FAIL sb_data: vid_data=%h expected %h", bus.vid_data, exp_v);
                        end
                    end
                end
                if (bus.cpu_valid) cpu_wait++;
                else cpu_wait = 0;
                checks++;
                if (vf && cf) begin
                    failures++;
                    $display("FAIL sb_excl: vid_fire=1 cpu_fire=1, expected at most one");
                end else if (cf) begin
                    if (bus.ram_en !== (bus.cpu_wmask != 3'b000) || bus.ram_we !== bus.cpu_wmask ||
                        (bus.cpu_wmask != 3'b000 && (bus.ram_addr !== bus.cpu_addr ||
                                                     bus.ram_wdata !== bus.cpu_wdata))) begin
                        failures++;
                        $display("FAIL sb_cpu_drive: en=%b we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                 bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                                 bus.cpu_wmask, bus.cpu_addr, bus.cpu_wdata);
                    end
                    checks++;
                    if (cpu_wait > LIMIT + 1) begin
                        failures++;
                        $display("FAIL sb_starve: cpu waited %0d cycles, limit %0d", cpu_wait, LIMIT + 1);
                    end
                    cpu_wait = 0;
                    shadow[bus.cpu_addr[9:0]] = merge(shadow[bus.cpu_addr[9:0]], bus.cpu_wdata, bus.cpu_wmask);
                end else if (vf) begin
                    if (bus.ram_en !== 1'b1 || bus.ram_we !== 3'b000 || bus.ram_addr !== bus.vid_addr) begin
                        failures++;
                        $display("FAIL sb_vid_drive: en=%b we=%b addr=%h expected en=1 we=000 addr=%h",
                                 bus.ram_en, bus.ram_we, bus.ram_addr, bus.vid_addr);
                    end
                    exp_q.push_back(shadow[bus.vid_addr[9:0]]);
                end else if (bus.ram_en !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_idle: ram_en=%b with no grant, expected 0", bus.ram_en);
                end
            end
        end
    end

    task automatic set_idle();
        bus.vid_addr_valid = 1'b0;
        bus.vid_addr       = '0;
        bus.vid_data_rdy   = 1'b0;
        bus.cpu_valid      = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_wdata      = '0;
        bus.cpu_wmask      = 3'b000;
    endtask

    task automatic drain();
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        bus.vid_addr_valid = 1'b1;
        bus.cpu_valid      = 1'b1;
        #1;
        checks++;
        if (bus.vid_data_valid !== 1'b0 || bus.vid_addr_rdy !== 1'b0 || bus.cpu_rdy !== 1'b0 ||
            bus.ram_en !== 1'b0 || bus.ram_we !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: dv=%b vrdy=%b crdy=%b en=%b we=%b expected all 0",
                     bus.vid_data_valid, bus.vid_addr_rdy, bus.cpu_rdy, bus.ram_en, bus.ram_we);
        end
        checks++;
        if (dut.fifo_count_q !== 2'd0 || dut.inflight_q !== 1'b0 || dut.starve_cnt_q !== '0) begin
            failures++;
            $display("FAIL reset_state: count=%0d inflight=%b starve=%0d expected 0",
                     dut.fifo_count_q, dut.inflight_q, dut.starve_cnt_q);
        end
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.vid_addr_rdy !== 1'b1 || bus.cpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: vrdy=%b crdy=%b expected 1 1", bus.vid_addr_rdy, bus.cpu_rdy);
        end
    endtask

    task automatic test_streaming();
        int bad_rdy = 0;
        int bad_dat = 0;
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            bus.vid_addr_valid = (c < 8);
            bus.vid_addr       = A'(c % 8);
            #1;
            if (c < 8 && bus.vid_addr_rdy !== 1'b1) bad_rdy++;
            if (c < 2 && bus.vid_data_valid !== 1'b0) bad_dat++;
            if (c >= 2 && (bus.vid_data_valid !== 1'b1 || bus.vid_data !== W'(c - 2))) begin
                bad_dat++;
                $display("FAIL stream_data: cycle %0d valid=%b data=%h expected 1 %h",
                         c, bus.vid_data_valid, bus.vid_data, W'(c - 2));
            end
        end
        checks++;
        if (bad_rdy != 0) begin
            failures++;
            $display("FAIL stream_rdy: vid_addr_rdy low on %0d of 8 cycles, expected 0", bad_rdy);
        end
        checks++;
        if (bad_dat != 0) begin
            failures++;
            $display("FAIL stream_timing: %0d bad data cycles, expected 0", bad_dat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc   = 0;
        int extra = 0;
        logic [W-1:0] got [$];
        @(negedge clk);
        set_idle();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            bus.vid_addr_valid = 1'b1;
            bus.vid_addr       = A'(32'h100 + acc);
            #1;
            if (c < 8 && bus.vid_addr_rdy) acc++;
        end
        checks++;
        if (acc != 3 || bus.vid_addr_rdy !== 1'b0 || dut.fifo_count_q !== 2'd3) begin
            failures++;
            $display("FAIL bp_fill: accepts=%0d vrdy=%b count=%0d expected 3 0 3",
                     acc, bus.vid_addr_rdy, dut.fifo_count_q);
        end
        @(negedge clk);
        bus.vid_data_rdy = 1'b1;
        #1;
        checks++;
        if (bus.vid_data !== 24'h000100 || bus.vid_addr_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop: head=%h vrdy=%b expected 000100 0", bus.vid_data, bus.vid_addr_rdy);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.vid_data_rdy = 1'b0;
            bus.vid_addr     = A'(32'h100 + acc);
            #1;
            if (bus.vid_addr_rdy) begin
                acc++;
                extra++;
            end
        end
        checks++;
        if (extra != 1) begin
            failures++;
            $display("FAIL bp_extra: further accepts=%0d expected 1", extra);
        end
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.vid_data_valid) got.push_back(bus.vid_data);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 24'h000101 || got[1] !== 24'h000102 || got[2] !== 24'h000103) begin
            failures++;
            $display("FAIL bp_order: %0d pops, first=%h expected 3 pops 000101 000102 000103",
                     got.size(), (got.size() > 0) ? got[0] : 24'hx);
        end
        drain();
    endtask

    task automatic test_starvation();
        int fire_cyc = 0;
        logic [2:0] we_at = '0;
        logic vrdy_at = 1'b1;
        logic [A-1:0] vaddr = A'(32'h20);
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            bus.vid_addr_valid = 1'b1;
            bus.vid_addr       = vaddr;
            bus.cpu_valid      = (k >= 1 && fire_cyc == 0);
            bus.cpu_addr       = A'(32'h00010);
            bus.cpu_wdata      = 24'hABCDEF;
            bus.cpu_wmask      = 3'b111;
            #1;
            if (bus.vid_addr_valid && bus.vid_addr_rdy) vaddr = vaddr + 1'b1;
            if (bus.cpu_valid && bus.cpu_rdy) begin
                fire_cyc = k;
                we_at    = bus.ram_we;
                vrdy_at  = bus.vid_addr_rdy;
            end
        end
        checks++;
        if (fire_cyc != LIMIT + 1 || we_at !== 3'b111 || vrdy_at !== 1'b0) begin
            failures++;
            $display("FAIL starve_fire: cycle=%0d we=%b vrdy=%b expected %0d 111 0",
                     fire_cyc, we_at, vrdy_at, LIMIT + 1);
        end
        checks++;
        if (dut.starve_cnt_q !== '0) begin
            failures++;
            $display("FAIL starve_clear: starve_cnt=%0d expected 0", dut.starve_cnt_q);
        end
        drain();
    endtask

    task automatic test_masked_write();
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        bus.cpu_valid = 1'b1; bus.cpu_addr = A'(5); bus.cpu_wdata = 24'h123456; bus.cpu_wmask = 3'b111;
        #1;
        checks++;
        if (bus.cpu_rdy !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_we !== 3'b111) begin
            failures++;
            $display("FAIL mw_full: crdy=%b en=%b we=%b expected 1 1 111", bus.cpu_rdy, bus.ram_en, bus.ram_we);
        end
        @(negedge clk);
        bus.cpu_wdata = 24'hFF0000; bus.cpu_wmask = 3'b100;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        bus.vid_addr_valid = 1'b1; bus.vid_addr = A'(5);
        @(negedge clk);
        bus.vid_addr_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.vid_data_valid !== 1'b1 || bus.vid_data !== 24'hFF3456) begin
            failures++;
            $display("FAIL mw_readback: valid=%b data=%h expected 1 ff3456", bus.vid_data_valid, bus.vid_data);
        end
        @(negedge clk);
        bus.cpu_valid = 1'b1; bus.cpu_addr = A'(5); bus.cpu_wdata = 24'h00ABCD; bus.cpu_wmask = 3'b000;
        #1;
        checks++;
        if (bus.cpu_rdy !== 1'b1 || bus.ram_en !== 1'b0) begin
            failures++;
            $display("FAIL mw_zero_mask: crdy=%b en=%b expected 1 0", bus.cpu_rdy, bus.ram_en);
        end
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        bus.vid_addr_valid = 1'b1; bus.vid_addr = A'(5);
        @(negedge clk);
        bus.vid_addr_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.vid_data !== 24'hFF3456) begin
            failures++;
            $display("FAIL mw_zero_readback: data=%h expected ff3456", bus.vid_data);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        int bad = 0;
        logic [W-1:0] got [$];
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            bus.vid_addr_valid = 1'b1;
            bus.vid_addr       = A'(32'h200 + i);
            #1;
            if (bus.vid_addr_rdy !== 1'b1) bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        bus.vid_addr = A'(32'h203);
        #1;
        checks++;
        if (bad != 0 || dut.fifo_count_q !== 2'd2 || dut.inflight_q !== 1'b1 || bus.ram_en !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: rdy_miss=%0d count=%0d inflight=%b en=%b expected 0 2 1 0",
                     bad, dut.fifo_count_q, dut.inflight_q, bus.ram_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.vid_data_valid !== 1'b0 || bus.vid_addr_rdy !== 1'b0 || bus.cpu_rdy !== 1'b0 ||
            bus.ram_en !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_flush: dv=%b vrdy=%b crdy=%b en=%b expected 0 0 0 0",
                     bus.vid_data_valid, bus.vid_addr_rdy, bus.cpu_rdy, bus.ram_en);
        end
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        bus.vid_data_rdy   = 1'b1;
        bus.vid_addr_valid = 1'b1;
        bus.vid_addr       = A'(32'h300);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.vid_addr_valid = 1'b0;
            end
            #1;
            if (bus.vid_data_valid) got.push_back(bus.vid_data);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 24'h000300) begin
            failures++;
            $display("FAIL rstmid_after: %0d pops first=%h expected 1 pop 000300",
                     got.size(), (got.size() > 0) ? got[0] : 24'hx);
        end
        drain();
    endtask

    task automatic test_idle_cpu();
        int bad = 0;
        @(negedge clk);
        set_idle();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            bus.cpu_valid = 1'b1;
            bus.cpu_addr  = A'($urandom_range(64, 127));
            bus.cpu_wdata = W'($urandom);
            bus.cpu_wmask = 3'($urandom_range(0, 7));
            #1;
            if (bus.cpu_rdy !== 1'b1 || bus.ram_en !== (bus.cpu_wmask != 3'b000) ||
                bus.ram_we !== bus.cpu_wmask) begin
                bad++;
                $display("FAIL idle_cpu: crdy=%b en=%b we=%b mask=%b expected crdy=1 we=mask",
                         bus.cpu_rdy, bus.ram_en, bus.ram_we, bus.cpu_wmask);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_cpu_total: %0d bad cycles, expected 0", bad);
        end
        drain();
    endtask

    task automatic test_random();
        logic vfired = 1'b1;
        logic cfired = 1'b1;
        @(negedge clk);
        set_idle();
        for (int c = 0; c < 800; c++) begin
            if (c > 0) @(negedge clk);
            if (!bus.vid_addr_valid || vfired) begin
                bus.vid_addr_valid = ($urandom_range(0, 3) != 0);
                bus.vid_addr       = A'($urandom_range(0, 15));
            end
            if (!bus.cpu_valid || cfired) begin
                bus.cpu_valid = ($urandom_range(0, 2) == 0);
                bus.cpu_addr  = A'($urandom_range(0, 15));
                bus.cpu_wdata = W'($urandom);
                bus.cpu_wmask = 3'($urandom_range(0, 7));
            end
            bus.vid_data_rdy = (c % 200 < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
            #1;
            vfired = bus.vid_addr_valid && bus.vid_addr_rdy;
            cfired = bus.cpu_valid && bus.cpu_rdy;
        end
        @(negedge clk);
        set_idle();
        bus.vid_data_rdy = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain: %0d reads never returned, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_starvation();
        test_masked_write();
        test_reset_midstream();
        test_idle_cpu();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
